// File: rtl/cfg_readback_7seg.sv
// cfg_readback_7seg
//
// Readback display for the switch-driven configuration registers. The
// register picked by h_select is shown on the 8-digit seven-segment display.
// Digit 7 shows the select index, digit 6 shows '-', digit 5 is blank and
// digits 4..0 show the register bits as '0'/'1' glyphs. If the select is
// invalid (6 or 7), digits 4..0 all show '-'.
//
// Anodes are scanned one digit at a time. The digit period is
// (ref_div+1)*2^REF_SHIFT clk cycles.
//
// Display content comes from a snapshot of {select, register}. The snapshot
// is taken once per frame, at the tick that wraps the digit index from 7 to 0,
// so a frame never mixes content from two selections.
//
// Optional feature, guarded by the macro CFG_READBACK_PUSH_FLASH_EN:
// a rising edge on push lights the decimal point of digit 7 for
// FLASH_FRAMES full scan frames. When the macro is undefined, push is
// ignored and dp stays high.
//
// Parameters:
//   REF_SHIFT    prescaler scale (default 10)
//   FLASH_FRAMES number of frames the push indicator stays lit (default 8)
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-low reset
//   en        in   scan enable; 0 blanks the display and parks the scan
//   ref_div   in   [4:0] refresh divider
//   h_select  in   [2:0] register selected for display
//   push      in   push-button level (rising edge = write)
//   h0,h1,h2,h4,h5 in [4:0] configuration registers
//   h3        in   [2:0] configuration register (zero-extended)
//   an        out  [7:0] anode enables, active-low
//   seg       out  [6:0] segments a..g, active-low
//   dp        out  decimal point, active-low

module cfg_readback_7seg #(
    parameter int REF_SHIFT    = 10,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] ref_div,
    input  logic [2:0] h_select,
    input  logic       push,
    input  logic [4:0] h0,
    input  logic [4:0] h1,
    input  logic [4:0] h2,
    input  logic [2:0] h3,
    input  logic [4:0] h4,
    input  logic [4:0] h5,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = 6 + REF_SHIFT;

    localparam logic [6:0] G_ZERO  = 7'b1000000;
    localparam logic [6:0] G_ONE   = 7'b1111001;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    // Hex glyph for a select index 0..7.
    function automatic logic [6:0] hex_glyph(input logic [2:0] v);
        logic [6:0] g;
        case (v)
            3'd0:    g = 7'b1000000;
            3'd1:    g = 7'b1111001;
            3'd2:    g = 7'b0100100;
            3'd3:    g = 7'b0110000;
            3'd4:    g = 7'b0011001;
            3'd5:    g = 7'b0010010;
            3'd6:    g = 7'b0000010;
            3'd7:    g = 7'b1111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    logic [CW-1:0] count_r;
    logic [CW-1:0] term_s;
    logic          tick_s;
    logic [2:0]    idx_r;
    logic [2:0]    sel_r;
    logic [4:0]    val_r;
    logic [4:0]    mux_s;
    logic [7:0]    val_ext_s;
    logic          sel_invalid_s;
    logic          frame_wrap_s;
    logic [6:0]    seg_next_s;
    logic          dp_next_s;

    // Terminal count and tick.
    // The count is compared with >=, so a ref_div that shrinks mid-count still
    // gives an immediate tick instead of a long count up through the wrap.
    always_comb begin
        term_s = ((CW'(ref_div) + CW'(1)) << REF_SHIFT) - CW'(1);
        tick_s = 1'b0;
        if (en && (count_r >= term_s)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    assign frame_wrap_s = tick_s && (idx_r == 3'd7);

    // Prescaler counter; held at 0 while the scan is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (!en || tick_s) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    // Digit index; advances on each tick and wraps 7 -> 0 through its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= 3'd0;
        end else if (!en) begin
            idx_r <= 3'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 3'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Register mux from the live select.
    always_comb begin
        mux_s = 5'd0;
        case (h_select)
            3'd0:    mux_s = h0;
            3'd1:    mux_s = h1;
            3'd2:    mux_s = h2;
            3'd3:    mux_s = {2'b00, h3};
            3'd4:    mux_s = h4;
            3'd5:    mux_s = h5;
            default: mux_s = 5'd0;
        endcase
    end

    // Frame snapshot, taken only at the frame wrap so that content cannot tear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_r <= 3'd0;
            val_r <= 5'd0;
        end else if (frame_wrap_s) begin
            sel_r <= h_select;
            val_r <= mux_s;
        end else begin
            sel_r <= sel_r;
            val_r <= val_r;
        end
    end

    // Glyph for the active digit, taken from the snapshot.
    always_comb begin
        seg_next_s    = G_BLANK;
        val_ext_s     = {3'b000, val_r};
        sel_invalid_s = (sel_r > 3'd5);
        case (idx_r)
            3'd7:    seg_next_s = hex_glyph(sel_r);
            3'd6:    seg_next_s = G_DASH;
            3'd5:    seg_next_s = G_BLANK;
            default: begin
                if (sel_invalid_s) begin
                    seg_next_s = G_DASH;
                end else if (val_ext_s[idx_r]) begin
                    seg_next_s = G_ONE;
                end else begin
                    seg_next_s = G_ZERO;
                end
            end
        endcase
    end

`ifdef CFG_READBACK_PUSH_FLASH_EN
    localparam int FW = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

    logic          push_r;
    logic [FW-1:0] flash_r;
    logic          push_edge_s;

    assign push_edge_s = push & ~push_r;

    // Push history and flash counter. A push edge reloads the counter, even
    // while the scan is disabled. Otherwise the counter counts down once per
    // frame wrap and saturates at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_r  <= 1'b0;
            flash_r <= '0;
        end else begin
            push_r <= push;
            if (push_edge_s) begin
                flash_r <= FW'(FLASH_FRAMES);
            end else if (frame_wrap_s && (flash_r != '0)) begin
                flash_r <= flash_r - FW'(1);
            end else begin
                flash_r <= flash_r;
            end
        end
    end

    // Decimal point is lit on digit 7 while a flash is pending.
    always_comb begin
        dp_next_s = 1'b1;
        if ((idx_r == 3'd7) && (flash_r != '0)) begin
            dp_next_s = 1'b0;
        end else begin
            dp_next_s = 1'b1;
        end
    end
`else
    localparam int unused_flash_frames = FLASH_FRAMES;
    logic unused_push_s;

    assign unused_push_s = push;
    assign dp_next_s     = 1'b1;
`endif

    // Registered display outputs; blanked while the scan is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (!en) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'd1 << idx_r);
            seg <= seg_next_s;
            dp  <= dp_next_s;
        end
    end

endmodule

// File: doc/cfg_readback_7seg.md
# cfg_readback_7seg

Readback side of the switch-driven configuration registers: continuously displays the register picked by `h_select` on the 8-digit seven-segment display.
- Digit 7 shows the select index; digits 4..0 show the register bits.
- Multiplexes anodes at a rate set by the `ref_div` configuration field and gated by the `AN_dec_en` enable.
- Sits between the switch handler outputs and the board's `AN`/`CA..CG`/`DP` pins.

## Interface
- `REF_SHIFT`, default 10: prescaler scale; digit period = (ref_div+1)·2^REF_SHIFT clk cycles.
- `FLASH_FRAMES`, default 8: number of full scan frames the push indicator stays lit.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan enable (AN_dec_en); 0 blanks the display.
- `ref_div`  in  5  refresh divider field.
- `h_select`  in  3  register currently selected.
- `push`  in  1  level from the push button; rising edge marks a write.
- `h0`, `h1`, `h2`, `h4`, `h5`  in  5 each  configuration registers.
- `h3`  in  3  configuration register, zero-extended to 5 bits internally.
- `an`  out  8  anode enables, active-low, `an[i]` selects digit i.
- `seg`  out  7  segments, active-low, `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Prescaler:** width 6+REF_SHIFT. `term` = ((ref_div+1)<<REF_SHIFT)−1. When count ≥ `term`, `tick`=1 and count→0; otherwise count+1. Using ≥ keeps the prescaler safe when `ref_div` shrinks mid-count.
- **Digit index:** 3 bits. Increments on `tick` and wraps 7→0.
- **Frame snapshot:** `{sel_q, val_q}` loads `h_select` and the selected register when `tick` and index==7. Every frame therefore starts with fresh, tear-free content.
- **Register mux:** select 0..5 → h0..h5. Select 6 or 7 is invalid.
- **Digit content (from snapshot):**
  - Digit 7: hex glyph of `sel_q`.
  - Digit 6: '-'.
  - Digit 5: blank.
  - Digits 4..0: '0'/'1' for `val_q[4..0]`, or '-' on all five when `sel_q` is invalid.
- **Glyphs (seg[6:0]):** '0'=1000000, '1'=1111001, '2'=0100100, '3'=0110000, '4'=0011001, '5'=0010010, '6'=0000010, '7'=1111000, '-'=0111111, blank=1111111.
- **Enable low:** prescaler and index held at 0; `an`=FF, `seg`=7F, `dp`=1 on the next edge. Snapshot is retained.
- **Enable rising:** scanning resumes from digit 0 with the existing snapshot.

## Timing
- **Reset values:** `an`=8'hFF, `seg`=7'h7F, `dp`=1. Prescaler, index, snapshot and flash counter are all 0. Push history register = 0.
- **Output latency:** all outputs are registered. `an`/`seg`/`dp` reflect the new index one clk after the `tick` edge. Exactly one `an` bit is low while `en`=1.
- **Push edge:** `push_q` is a registered copy of `push`; a rising edge is `push & ~push_q`.
- **Simultaneous events:** snapshot load and push edge on the same edge both take effect. Push edge while `en`=0 still loads the flash counter.
- **Reset mid-scan:** asynchronous return to reset values. The first `tick` after release occurs `term`+1 cycles later.

## Configuration
- `CFG_READBACK_PUSH_FLASH_EN` defined:
  - A push rising edge loads the flash counter with FLASH_FRAMES.
  - The counter decrements on each frame wrap (tick with index 7→0) and saturates at 0.
  - `dp` is driven low while digit 7 is active and the counter ≠ 0.
  - A push during an active flash reloads the counter.
- Macro undefined: no flash counter or push logic; `dp` is constantly 1 and `push` is ignored.

## Test plan
- **Reset:** REF_SHIFT=2, ref_div=0, en=1, assert rst=0 mid-scan → `an`=FF, `seg`=7F, `dp`=1 immediately. After release, the first tick comes 4 cycles later and `an`=FE one cycle after it.
- **Scan rate/wrap:** ref_div=2, REF_SHIFT=2 → `an` advances every 12 cycles through FE,FD,…,7F, then back to FE.
- **Content:** h_select=3, h3=3'b101 → after the frame boundary, digit7 `seg`=0110000, digit6 0111111, digit5 1111111, digits4..0 = 0,0,1,0,1 glyphs. h_select=6 → digits4..0 all 0111111, digit7 0000010.
- **Tear-free:** change h_select 1→2 while index=3 → digits keep h1 content until after the next index 7→0 wrap, then show h2.
- **ref_div shrink:** ref_div 31→0 while count=50 (REF_SHIFT=2) → tick on the next edge, then every 4 cycles.
- **Flash (macro on):** FLASH_FRAMES=2, pulse push → `dp`=0 only while `an`=7F, for 2 frames, then 1. Repeat with the macro off → `dp` stays 1.
